// File: rtl/digit_scanner.sv
// Scan driver for the 8-digit multiplexed display: rotates an active-low one-hot
// select across enabled digits, with an optional all-off gap between digits.
module digit_scanner #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] digit_mask,
    output logic [7:0] sel,
    output logic [2:0] digit_idx,
    output logic       blank,
    output logic       frame_done
);

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        GAP
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [7:0]       sel_d;
    logic [2:0]       idx_d;
    logic             blank_d;
    logic             frame_done_d;
    logic [2:0]       first_idx;
    logic [2:0]       next_idx;
    logic             advance;
    logic             go_idle;

    // Circular search starting just after cur; cur itself is the last candidate.
    function automatic logic [2:0] next_enabled(input logic [7:0] mask, input logic [2:0] cur);
        logic [2:0] res;
        logic [2:0] cand;
        res = cur;
        for (int k = 8; k >= 1; k--) begin
            cand = cur + 3'(k);
            if (mask[cand]) res = cand;
        end
        return res;
    endfunction

    function automatic logic [2:0] lowest_enabled(input logic [7:0] mask);
        logic [2:0] res;
        res = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (mask[k]) res = 3'(k);
        end
        return res;
    endfunction

    always_comb begin
        state_d      = state;
        cnt_d        = cnt + CNT_W'(1);
        sel_d        = sel;
        idx_d        = digit_idx;
        blank_d      = blank;
        frame_done_d = 1'b0;
        advance      = 1'b0;
        go_idle      = 1'b0;
        first_idx    = lowest_enabled(digit_mask);
        next_idx     = next_enabled(digit_mask, digit_idx);

        case (state)
            IDLE: begin
                cnt_d   = '0;
                sel_d   = 8'hFF;
                blank_d = 1'b1;
                if (en && digit_mask != 8'h00) begin
                    state_d = ON;
                    idx_d   = first_idx;
                    sel_d   = ~(8'b1 << first_idx);
                    blank_d = 1'b0;
                end
            end
            ON: begin
                if (!en || digit_mask == 8'h00) begin
                    go_idle = 1'b1;
                end else if (cnt == ON_LAST) begin
                    if (BLANK_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = '0;
                        sel_d   = 8'hFF;
                        blank_d = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            GAP: begin
                if (!en || digit_mask == 8'h00) begin
                    go_idle = 1'b1;
                end else if (cnt == GAP_LAST) begin
                    advance = 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        // A wrap back to an equal or lower digit marks the end of a frame.
        if (go_idle) begin
            state_d = IDLE;
            cnt_d   = '0;
            sel_d   = 8'hFF;
            blank_d = 1'b1;
        end else if (advance) begin
            state_d      = ON;
            cnt_d        = '0;
            idx_d        = next_idx;
            sel_d        = ~(8'b1 << next_idx);
            blank_d      = 1'b0;
            frame_done_d = (next_idx <= digit_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= 8'hFF;
            digit_idx  <= 3'd0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sel        <= sel_d;
            digit_idx  <= idx_d;
            blank      <= blank_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_digit_scanner.sv
// Self-checking bench for digit_scanner: directed scenarios plus random enable/mask
// traffic compared against a schedule-based reference model.
module tb_digit_scanner;

    localparam int CLK_DIV = 4;
    localparam int BLANK   = 2;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [7:0] mask;
    logic [7:0] sel;
    logic [2:0] digit_idx;
    logic       blank, frame_done;

    logic       rst1, en1;
    logic [7:0] mask1;
    logic [7:0] sel1;
    logic [2:0] digit_idx1;
    logic       blank1, frame_done1;

    int total = 0;
    int bad   = 0;

    // Reference model: each visit to a digit is a precomputed list of output cycles.
    bit         m_active;
    logic [7:0] m_sel;
    logic [2:0] m_idx;
    logic       m_fd;
    logic [7:0] q_sel[$];
    bit         q_fd[$];

    always #5 clk = ~clk;

    digit_scanner #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .rst(rst), .en(en), .digit_mask(mask),
        .sel(sel), .digit_idx(digit_idx), .blank(blank), .frame_done(frame_done)
    );

    digit_scanner #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(0)) dut_nogap (
        .clk(clk), .rst(rst1), .en(en1), .digit_mask(mask1),
        .sel(sel1), .digit_idx(digit_idx1), .blank(blank1), .frame_done(frame_done1)
    );

    function automatic int model_lowest(input logic [7:0] m);
        for (int k = 0; k < 8; k++) if (m[k]) return k;
        return 0;
    endfunction

    function automatic int model_next(input logic [7:0] m, input int cur);
        for (int k = 1; k <= 8; k++) if (m[(cur + k) % 8]) return (cur + k) % 8;
        return cur;
    endfunction

    task automatic model_schedule(input int d, input bit fd);
        m_idx = 3'(d);
        for (int i = 0; i < CLK_DIV; i++) begin
            q_sel.push_back(8'hFF ^ (8'h01 << d));
            q_fd.push_back(i == 0 ? fd : 1'b0);
        end
        for (int i = 0; i < BLANK; i++) begin
            q_sel.push_back(8'hFF);
            q_fd.push_back(1'b0);
        end
    endtask

    task automatic model_edge();
        int nxt;
        if (rst) begin
            m_active = 0; q_sel.delete(); q_fd.delete();
            m_sel = 8'hFF; m_idx = 3'd0; m_fd = 1'b0;
        end else if (m_active && (!en || mask == 8'h00)) begin
            m_active = 0; q_sel.delete(); q_fd.delete();
            m_sel = 8'hFF; m_fd = 1'b0;
        end else if (!m_active) begin
            m_fd = 1'b0;
            m_sel = 8'hFF;
            if (en && mask != 8'h00) begin
                m_active = 1;
                model_schedule(model_lowest(mask), 1'b0);
                m_sel = q_sel.pop_front();
                m_fd  = q_fd.pop_front();
            end
        end else begin
            if (q_sel.size() == 0) begin
                nxt = model_next(mask, int'(m_idx));
                model_schedule(nxt, nxt <= int'(m_idx));
            end
            m_sel = q_sel.pop_front();
            m_fd  = q_fd.pop_front();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; mask = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({sel, digit_idx, blank, frame_done} !== {8'hFF, 3'd0, 1'b1, 1'b0}) begin
                bad++;
                $display("[TB] FAIL reset_%0d: got sel=%h idx=%0d blank=%b fd=%b, want sel=ff idx=0 blank=1 fd=0",
                         c, sel, digit_idx, blank, frame_done);
            end
        end
    endtask

    task automatic test_full_scan();
        int pulses = 0;
        rst = 0; en = 1; mask = 8'hFF;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (frame_done === 1'b1) pulses++;
            total++;
            if ({sel, digit_idx, blank, frame_done} !== {m_sel, m_idx, m_sel == 8'hFF, m_fd}) begin
                bad++;
                $display("[TB] FAIL full_scan_%0d: got sel=%h idx=%0d blank=%b fd=%b, want sel=%h idx=%0d blank=%b fd=%b",
                         c, sel, digit_idx, blank, frame_done, m_sel, m_idx, m_sel == 8'hFF, m_fd);
            end
        end
        total++;
        if (pulses !== 2) begin
            bad++;
            $display("[TB] FAIL full_scan_pulses: got %0d, want 2", pulses);
        end
    endtask

    task automatic test_sparse_mask();
        int starts[$];
        int exp_starts[4] = '{0, 2, 5, 0};
        logic [7:0] prev;
        en = 0; tick();
        prev = sel;
        en = 1; mask = 8'b0010_0101;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (prev === 8'hFF && sel !== 8'hFF) starts.push_back(int'(digit_idx));
            prev = sel;
            total++;
            if ({sel, digit_idx, blank, frame_done} !== {m_sel, m_idx, m_sel == 8'hFF, m_fd}) begin
                bad++;
                $display("[TB] FAIL sparse_%0d: got sel=%h idx=%0d blank=%b fd=%b, want sel=%h idx=%0d blank=%b fd=%b",
                         c, sel, digit_idx, blank, frame_done, m_sel, m_idx, m_sel == 8'hFF, m_fd);
            end
        end
        total++;
        if (starts.size() < 4) begin
            bad++;
            $display("[TB] FAIL sparse_starts: got %0d digit starts, want at least 4", starts.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (starts[i] !== exp_starts[i]) begin
                    bad++;
                    $display("[TB] FAIL sparse_start_%0d: got idx %0d, want %0d", i, starts[i], exp_starts[i]);
                end
            end
        end
    endtask

    task automatic test_single_digit();
        int waited = 0;
        en = 0; tick();
        en = 1; mask = 8'h10;
        for (int c = 0; c < 18; c++) begin
            tick();
            total++;
            if ({sel, digit_idx, blank, frame_done} !== {m_sel, m_idx, m_sel == 8'hFF, m_fd}) begin
                bad++;
                $display("[TB] FAIL single_%0d: got sel=%h idx=%0d blank=%b fd=%b, want sel=%h idx=%0d blank=%b fd=%b",
                         c, sel, digit_idx, blank, frame_done, m_sel, m_idx, m_sel == 8'hFF, m_fd);
            end
        end
        while (sel !== 8'hEF && waited < 20) begin
            tick();
            waited++;
        end
        total++;
        if (sel !== 8'hEF) begin
            bad++;
            $display("[TB] FAIL single_wait_on: got sel=%h, want ef within 20 cycles", sel);
        end
        en = 0; tick();
        total++;
        if ({sel, digit_idx, blank} !== {8'hFF, 3'd4, 1'b1}) begin
            bad++;
            $display("[TB] FAIL single_disable: got sel=%h idx=%0d blank=%b, want sel=ff idx=4 blank=1",
                     sel, digit_idx, blank);
        end
        en = 1; tick();
        total++;
        if ({sel, frame_done} !== {8'hEF, 1'b0}) begin
            bad++;
            $display("[TB] FAIL single_reenable: got sel=%h fd=%b, want sel=ef fd=0", sel, frame_done);
        end
    endtask

    task automatic test_mask_change();
        int waited = 0;
        en = 0; tick();
        en = 1; mask = 8'hFF;
        tick();
        while (sel !== 8'hFB && waited < 50) begin
            tick();
            waited++;
        end
        total++;
        if (sel !== 8'hFB) begin
            bad++;
            $display("[TB] FAIL mask_change_wait: got sel=%h, want fb within 50 cycles", sel);
        end
        mask = 8'h01;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if ({sel, digit_idx, blank, frame_done} !== {m_sel, m_idx, m_sel == 8'hFF, m_fd}) begin
                bad++;
                $display("[TB] FAIL mask_change_%0d: got sel=%h idx=%0d blank=%b fd=%b, want sel=%h idx=%0d blank=%b fd=%b",
                         c, sel, digit_idx, blank, frame_done, m_sel, m_idx, m_sel == 8'hFF, m_fd);
            end
        end
        total++;
        if ({sel, frame_done} !== {8'hFE, 1'b1}) begin
            bad++;
            $display("[TB] FAIL mask_change_wrap: got sel=%h fd=%b, want sel=fe fd=1", sel, frame_done);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 11) == 0) mask = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            en  = ($urandom_range(0, 15) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
            total++;
            if ({sel, digit_idx, blank, frame_done} !== {m_sel, m_idx, m_sel == 8'hFF, m_fd}) begin
                bad++;
                $display("[TB] FAIL random_%0d: got sel=%h idx=%0d blank=%b fd=%b, want sel=%h idx=%0d blank=%b fd=%b",
                         c, sel, digit_idx, blank, frame_done, m_sel, m_idx, m_sel == 8'hFF, m_fd);
            end
        end
        rst = 0;
    endtask

    task automatic test_reset_mid_scan();
        en = 1; mask = 8'hFF;
        for (int c = 0; c < 9; c++) tick();
        rst = 1; tick();
        total++;
        if ({sel, digit_idx, blank, frame_done} !== {8'hFF, 3'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_mid: got sel=%h idx=%0d blank=%b fd=%b, want sel=ff idx=0 blank=1 fd=0",
                     sel, digit_idx, blank, frame_done);
        end
        rst = 0;
    endtask

    task automatic test_no_blank();
        logic [7:0] exp_sel;
        logic [2:0] exp_idx;
        logic       exp_fd;
        en1 = 1; mask1 = 8'h03; rst1 = 1;
        tick();
        rst1 = 0;
        for (int c = 0; c < 18; c++) begin
            tick();
            exp_idx = 3'((c / CLK_DIV) % 2);
            exp_sel = (exp_idx == 3'd0) ? 8'hFE : 8'hFD;
            exp_fd  = (c % (2 * CLK_DIV) == 0) && (c != 0);
            total++;
            if ({sel1, digit_idx1, blank1, frame_done1} !== {exp_sel, exp_idx, 1'b0, exp_fd}) begin
                bad++;
                $display("[TB] FAIL no_blank_%0d: got sel=%h idx=%0d blank=%b fd=%b, want sel=%h idx=%0d blank=0 fd=%b",
                         c, sel1, digit_idx1, blank1, frame_done1, exp_sel, exp_idx, exp_fd);
            end
        end
        rst1 = 1; tick();
        total++;
        if ({sel1, digit_idx1, blank1, frame_done1} !== {8'hFF, 3'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL no_blank_reset: got sel=%h idx=%0d blank=%b fd=%b, want sel=ff idx=0 blank=1 fd=0",
                     sel1, digit_idx1, blank1, frame_done1);
        end
    endtask

    initial begin
        rst = 1; en = 0; mask = 8'h00;
        rst1 = 1; en1 = 0; mask1 = 8'h00;
        m_active = 0; m_sel = 8'hFF; m_idx = 3'd0; m_fd = 1'b0;
        #1;
        test_reset();
        test_full_scan();
        test_sparse_mask();
        test_single_digit();
        test_mask_change();
        test_random();
        test_reset_mid_scan();
        test_no_blank();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_scanner.md
Name: digit_scanner

Overview:
- Scan driver for the 8-digit multiplexed display in the elevator design.
- Generates the active-low one-hot digit select bus consumed by the digit data selector; the selector maps select 8'b11111110..8'b01111111 to digit data 1..8.
- Rotates through enabled digits at a fixed on-time, inserts an all-off blanking gap between digits to prevent ghosting, and flags each completed frame.

Parameters:
- CLK_DIV, 50000, clock cycles each digit is driven (on-time); legal range >= 1.
- BLANK_CYCLES, 500, clock cycles of all-off gap between digits; 0 removes the gap.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  scan enable; 0 forces display off.
- digit_mask  in  8  bit i=1 enables digit i (bit 0 = digit 1 = select 8'b11111110).
- sel  out  8  active-low one-hot digit select; 8'hFF = all digits off.
- digit_idx  out  3  index of the digit currently driven or last driven (0..7).
- blank  out  1  1 whenever sel = 8'hFF (IDLE or GAP).
- frame_done  out  1  one-cycle pulse on scan wrap-around.

Behaviour:
- All outputs registered. Reset values: sel=8'hFF, digit_idx=0, blank=1, frame_done=0, state=IDLE, counters=0. A reset asserted in any state takes effect at the next edge.
- States: IDLE, ON, GAP.
- IDLE: sel=8'hFF. At an edge with en=1 and digit_mask!=0, digit_idx <= lowest set bit of digit_mask, sel <= ~(1<<idx), state <= ON, and the counter clears. frame_done stays 0 on IDLE->ON.
- ON: sel holds exactly CLK_DIV cycles. At the end of the on-time:
  - If BLANK_CYCLES>0: sel <= 8'hFF and state <= GAP.
  - Otherwise: advance directly, as at the end of GAP.
- GAP: sel=8'hFF for exactly BLANK_CYCLES cycles, then advance.
- Advance:
  - The next index is the first set bit of digit_mask, searching circularly from digit_idx+1 (wrapping 7->0) and including digit_idx itself last.
  - digit_idx and sel update on the same edge and state <= ON.
  - frame_done=1 for that one cycle if next index <= current index (wrap). With a single enabled digit, frame_done pulses on every re-entry.
- digit_mask is sampled only at IDLE exit and at advance. A digit masked mid-ON completes its on-time.
- en=0 or digit_mask=0 in ON or GAP: next edge goes to IDLE with sel=8'hFF, counters cleared, and digit_idx held. Re-enable restarts at the lowest enabled digit.
- Exactly one sel bit is low in ON; no sel bit is low in IDLE or GAP.
- Counter widths are $clog2 of max(CLK_DIV, BLANK_CYCLES)+1. The counter never wraps and is cleared on every state change.

Test Plan (CLK_DIV=4, BLANK_CYCLES=2 unless noted):
- rst=1 for 3 cycles with en=1, mask=8'hFF -> sel=8'hFF, digit_idx=0, blank=1, frame_done=0 throughout.
- en=1, mask=8'hFF -> sel=FE x4, FF x2, FD x4, FF x2 ... 7F x4, FF x2, then FE with frame_done=1 for exactly 1 cycle; 48-cycle frame period repeats.
- mask=8'b00100101 -> sel cycles FE, FB, DF (each 4 cycles, 2-cycle FF gaps), then FE with frame_done=1; digit_idx goes 0, 2, 5, 0.
- mask=8'h10 -> sel=EF x4, FF x2 repeating; frame_done=1 on every return to EF. Drop en to 0 mid-ON -> sel=8'hFF next cycle. Re-assert en -> EF one cycle later.
- Change mask from 8'hFF to 8'h01 during digit 3 ON (sel=FB) -> FB completes 4 cycles, FF x2, then FE with frame_done=1.
- BLANK_CYCLES=0, mask=8'h03 -> sel=FE x4, FD x4, FE ... with no FF cycles. Assert rst mid-ON -> sel=8'hFF and digit_idx=0 at next edge.
